// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads a window of a synchronous-read BRAM and
// streams it out on AXI-Stream, one beat per word, tlast per frame.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start, loop_en     command pulse, continuous-repeat enable
//   base_addr, length  frame window (first word, word count)
//   busy, done         command active, one-cycle completion pulse
//   bram_en/addr/dout  BRAM read port
//   m_axis_*           AXI-Stream master (tdata/tvalid/tready/tlast)
module bram_stream_reader #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 32,
  parameter int ADDR_WIDTH   = $clog2(DEPTH),
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  loop_en,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  bram_en,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_dout,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int RL        = READ_LATENCY;
  localparam int BUF_DEPTH = RL + 2;
  localparam int PW        = $clog2(BUF_DEPTH);
  localparam int CW        = $clog2(BUF_DEPTH + 1);
  localparam int LW        = ADDR_WIDTH + 1;

  localparam logic [LW-1:0] DEPTH_L =
    LW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX =
    ADDR_WIDTH'(DEPTH - 1);
  localparam logic [PW-1:0] PTR_MAX =
    PW'(BUF_DEPTH - 1);
  localparam logic [CW:0] BUF_L =
    (CW + 1)'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t state;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         idx;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  en_last;

  // tag pipe tracking each read until its data appears on bram_dout
  logic [RL-1:0] pv;
  logic [RL-1:0] pl;

  // reads issued but not yet written into the FIFO
  logic [CW-1:0] inflight;

  logic [DATA_WIDTH-1:0] fmem [BUF_DEPTH];
  logic [BUF_DEPTH-1:0]  flast;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         fcount;

  logic                  start_ok;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  src_last;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [ADDR_WIDTH-1:0] loop_addr;
  logic [LW-1:0]         src_idx;
  logic [LW-1:0]         src_len;
  logic [CW:0]           occ;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PTR_MAX) ? '0 : p + PW'(1);
  endfunction

  assign m_axis_tvalid = (fcount != '0);
  assign m_axis_tdata  = fmem[rd_ptr];
  assign m_axis_tlast  = m_axis_tvalid
                       & flast[rd_ptr];

  assign push = pv[RL-1];
  assign pop  = m_axis_tvalid & m_axis_tready;

  always_comb begin
    start_ok  = 1'b0;
    issue     = 1'b0;
    src_addr  = cur_addr;
    src_idx   = idx;
    src_len   = len_q;
    loop_addr = base_q;
    // Issue the first read straight from IDLE so the
    // first bram_en appears the cycle after start.
    if (state == S_IDLE) begin
      src_addr  = base_addr;
      src_idx   = '0;
      src_len   = length;
      loop_addr = base_addr;
      start_ok  = start
                & (length != '0)
                & (length <= DEPTH_L)
                & ({1'b0, base_addr} < DEPTH_L);
    end
    src_last = (src_idx == src_len - LW'(1));
    nxt_addr = (src_addr == ADDR_MAX)
             ? '0 : src_addr + ADDR_WIDTH'(1);
    // A pop this cycle frees a slot before the new
    // read can land, so count it as returned credit.
    occ = {1'b0, inflight}
        + {1'b0, fcount}
        - {{CW{1'b0}}, pop};
    issue = start_ok
          | ((state == S_RUN) & (occ < BUF_L));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      bram_en   <= 1'b0;
      bram_addr <= '0;
      base_q    <= '0;
      len_q     <= '0;
      idx       <= '0;
      cur_addr  <= '0;
      en_last   <= 1'b0;
      pv        <= '0;
      pl        <= '0;
      inflight  <= '0;
      flast     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fcount    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++)
        fmem[i] <= '0;
    end else begin
      done    <= 1'b0;
      bram_en <= issue;
      if (issue) begin
        bram_addr <= src_addr;
        en_last   <= src_last;
      end

      pv[0] <= bram_en;
      pl[0] <= en_last;
      for (int i = 1; i < RL; i++) begin
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
      end

      inflight <= inflight
                + CW'(issue)
                - CW'(push);

      if (push) begin
        fmem[wr_ptr]  <= bram_dout;
        flast[wr_ptr] <= pl[RL-1];
        wr_ptr        <= ptr_inc(wr_ptr);
      end
      if (pop)
        rd_ptr <= ptr_inc(rd_ptr);
      fcount <= fcount
              + CW'(push)
              - CW'(pop);

      case (state)
        S_IDLE: begin
          if (start_ok) begin
            busy   <= 1'b1;
            base_q <= base_addr;
            len_q  <= length;
          end
        end
        S_RUN: begin
        end
        S_DRAIN: begin
          if (inflight == '0 && fcount == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Frame bookkeeping; loop_en is looked at only
      // when the last word of a frame is issued.
      if (issue) begin
        if (src_last) begin
          if (loop_en) begin
            idx      <= '0;
            cur_addr <= loop_addr;
            state    <= S_RUN;
          end else begin
            state <= S_DRAIN;
          end
        end else begin
          idx      <= src_idx + LW'(1);
          cur_addr <= nxt_addr;
          state    <= S_RUN;
        end
      end
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: scoreboard bench for bram_stream_reader
// over four DEPTH / READ_LATENCY configurations run side by side.
module tb_bram_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int fin   = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int D  = (g == 3) ? 20 : 32;
    localparam int RL = (g == 1) ? 1
                      : ((g == 2) ? 3 : 2);
    localparam int AW = $clog2(D);

    logic          rst;
    logic          start;
    logic          loop_en;
    logic          tready;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_dout;
    logic [31:0]   tdata;
    logic          tvalid;
    logic          tlast;

    logic [31:0] rp [RL];

    beat_t q[$];
    int nbeats  = 0;
    int tcount  = 0;
    int first_t = -1;
    int last_t  = -1;
    logic        stall = 1'b0;
    logic [31:0] hd;
    logic        hl;

    bram_stream_reader #(
      .DATA_WIDTH  (32),
      .DEPTH       (D),
      .READ_LATENCY(RL)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .loop_en      (loop_en),
      .base_addr    (base),
      .length       (len),
      .busy         (busy),
      .done         (done),
      .bram_en      (bram_en),
      .bram_addr    (bram_addr),
      .bram_dout    (bram_dout),
      .m_axis_tdata (tdata),
      .m_axis_tvalid(tvalid),
      .m_axis_tready(tready),
      .m_axis_tlast (tlast)
    );

    // BRAM holding word i at address i
    always @(posedge clk) begin
      rp[0] <= bram_en ? 32'(bram_addr)
                       : 32'hDEAD_BEEF;
      for (int i = 1; i < RL; i++)
        rp[i] <= rp[i-1];
    end
    assign bram_dout = rp[RL-1];

    // monitor / scoreboard
    always @(negedge clk) begin
      beat_t e;
      tcount++;
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          chk($sformatf("c%0d_hold_valid", g),
              32'(tvalid), 1);
          chk($sformatf("c%0d_hold_data", g),
              tdata, hd);
          chk($sformatf("c%0d_hold_last", g),
              32'(tlast), 32'(hl));
        end
        if (tvalid && tready) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL c%0d_extra_beat: got %0d want none",
                     g, tdata);
          end else begin
            e = q.pop_front();
            chk($sformatf("c%0d_data", g),
                tdata, e.d);
            chk($sformatf("c%0d_last", g),
                32'(tlast), 32'(e.l));
          end
          nbeats++;
          if (first_t < 0) first_t = tcount;
          last_t = tcount;
        end
        stall = tvalid && !tready;
        hd    = tdata;
        hl    = tlast;
      end
    end

    task automatic tick();
      @(posedge clk);
      #1;
    endtask

    task automatic push_frame(int b, int n);
      beat_t e;
      for (int i = 0; i < n; i++) begin
        e.d = 32'((b + i) % D);
        e.l = (i == n - 1);
        q.push_back(e);
      end
    endtask

    task automatic send(int b, int n,
                        logic lp,
                        output int t1);
      base    = AW'(b);
      len     = (AW + 1)'(n);
      loop_en = lp;
      start   = 1'b1;
      first_t = -1;
      tick();
      start = 1'b0;
      t1    = tcount + 1;
    endtask

    task automatic wait_done(string nm);
      logic got = 1'b0;
      for (int k = 0; k < 2000 && !got; k++) begin
        @(negedge clk);
        if (done) got = 1'b1;
      end
      chk({nm, "_done"}, 32'(got), 1);
      chk({nm, "_busy_at_done"}, 32'(busy), 0);
      @(negedge clk);
      chk({nm, "_pulse"}, 32'(done), 0);
      chk({nm, "_idle"}, 32'(busy), 0);
      chk({nm, "_drained"}, q.size(), 0);
      tick();
    endtask

    task automatic chk_zero(string nm);
      chk({nm, "_busy"}, 32'(busy), 0);
      chk({nm, "_done"}, 32'(done), 0);
      chk({nm, "_en"}, 32'(bram_en), 0);
      chk({nm, "_addr"}, 32'(bram_addr), 0);
      chk({nm, "_tvalid"}, 32'(tvalid), 0);
      chk({nm, "_tlast"}, 32'(tlast), 0);
      chk({nm, "_tdata"}, tdata, 0);
    endtask

    initial begin
      int t1;
      int nb0;
      int k;
      logic got;
      logic [7:0] lfsr;
      string p;
      p       = $sformatf("c%0d", g);
      rst     = 1'b1;
      start   = 1'b0;
      loop_en = 1'b0;
      tready  = 1'b1;
      base    = '0;
      len     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero({p, "_rst"});
      tick();
      rst = 1'b0;
      tick();

      // basic frame: timing and contiguity
      push_frame(0, 8);
      send(0, 8, 1'b0, t1);
      @(negedge clk);
      chk({p, "_basic_en"}, 32'(bram_en), 1);
      chk({p, "_basic_addr"}, 32'(bram_addr), 0);
      chk({p, "_basic_busy"}, 32'(busy), 1);
      wait_done({p, "_basic"});
      chk({p, "_basic_lat"}, first_t - t1, RL + 1);
      chk({p, "_basic_span"}, last_t - first_t, 7);

      // wrap around the top of memory
      push_frame(D - 2, 5);
      send(D - 2, 5, 1'b0, t1);
      wait_done({p, "_wrap"});
      chk({p, "_wrap_span"}, last_t - first_t, 4);

      // backpressure: pseudo-random ready plus long stall
      nb0  = nbeats;
      lfsr = 8'hA5;
      got  = 1'b0;
      push_frame(0, 16);
      send(0, 16, 1'b0, t1);
      for (int c = 0; c < 1000 && !got; c++) begin
        tready = (c >= 6 && c < 26) ? 1'b0
               : (lfsr[0] | lfsr[2]);
        lfsr = {lfsr[6:0],
                lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        @(negedge clk);
        if (done) got = 1'b1;
        tick();
      end
      tready = 1'b1;
      chk({p, "_bp_done"}, 32'(got), 1);
      chk({p, "_bp_count"}, nbeats - nb0, 16);
      chk({p, "_bp_drained"}, q.size(), 0);
      tick();

      // loop mode: loop_en dropped mid fourth frame
      for (int f = 0; f < 4; f++) push_frame(4, 3);
      send(4, 3, 1'b1, t1);
      repeat (10) @(posedge clk);
      #1;
      loop_en = 1'b0;
      wait_done({p, "_loop"});
      chk({p, "_loop_span"}, last_t - first_t, 11);

      // illegal lengths are ignored
      send(0, 0, 1'b0, t1);
      @(negedge clk);
      chk({p, "_len0_busy"}, 32'(busy), 0);
      chk({p, "_len0_en"}, 32'(bram_en), 0);
      repeat (3) @(negedge clk);
      chk({p, "_len0_busy2"}, 32'(busy), 0);
      tick();
      send(0, D + 1, 1'b0, t1);
      @(negedge clk);
      chk({p, "_lenbig_busy"}, 32'(busy), 0);
      chk({p, "_lenbig_en"}, 32'(bram_en), 0);
      repeat (3) @(negedge clk);
      chk({p, "_lenbig_busy2"}, 32'(busy), 0);
      tick();

      // start while running is ignored
      push_frame(10, 8);
      send(10, 8, 1'b0, t1);
      tick();
      tick();
      base  = '0;
      len   = (AW + 1)'(3);
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done({p, "_ovl"});
      chk({p, "_ovl_span"}, last_t - first_t, 7);
      repeat (3) @(negedge clk);
      chk({p, "_ovl_en"}, 32'(bram_en), 0);
      chk({p, "_ovl_busy"}, 32'(busy), 0);
      tick();

      // reset after three beats of a ten word frame
      nb0 = nbeats;
      push_frame(0, 10);
      send(0, 10, 1'b0, t1);
      k = 0;
      while (nbeats < nb0 + 3 && k < 100) begin
        tick();
        k++;
      end
      chk({p, "_mid_reached"}, 32'(k < 100), 1);
      rst    = 1'b1;
      tready = 1'b0;
      q.delete();
      tick();
      rst    = 1'b0;
      tready = 1'b1;
      @(negedge clk);
      chk_zero({p, "_mid"});
      nb0 = nbeats;
      repeat (12) @(negedge clk);
      chk({p, "_mid_quiet"}, nbeats - nb0, 0);
      tick();
      push_frame(0, 10);
      send(0, 10, 1'b0, t1);
      wait_done({p, "_after"});
      chk({p, "_after_span"}, last_t - first_t, 9);

      fin++;
    end
  end

  initial begin
    int k;
    for (k = 0; k < 60000 && fin < 4; k++)
      @(posedge clk);
    if (fin < 4) begin
      total++;
      bad++;
      $display("FAIL timeout: %0d of 4 configs finished",
               fin);
    end
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
